// File: rtl/mem_responder.sv
// Word-organised RAM target with a req/ack handshake, byte-enabled stores,
// programmable wait states and an error response for misaligned or out-of-range accesses.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int BASE_ADDR   = 0,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] Address,
   input  logic [31:0] DataOut,
   output logic [31:0] DataIn,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] BASE      = 32'(BASE_ADDR);
   localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        we_reg;
   logic [3:0]  be_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        bad_reg;
   logic [31:0] hold_reg;

   logic          accept;
   logic          enter_resp;
   logic          acc_we;
   logic [3:0]    acc_be;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [32:0]   acc_diff;
   logic [31:0]   acc_off;
   logic          acc_below;
   logic          acc_over;
   logic          acc_bad;
   logic [AW-1:0] acc_idx;
   logic [31:0]   rd_word;

   assign accept = (state_reg == S_IDLE) && req;

   // With zero wait states the RAM is touched on the accepting edge, so the live inputs are used there.
   assign acc_we    = (state_reg == S_IDLE) ? we      : we_reg;
   assign acc_be    = (state_reg == S_IDLE) ? be      : be_reg;
   assign acc_addr  = (state_reg == S_IDLE) ? Address : addr_reg;
   assign acc_wdata = (state_reg == S_IDLE) ? DataOut : wdata_reg;

   // Borrow out of the 33-bit subtraction flags an address below the base.
   assign acc_diff  = {1'b0, acc_addr} - {1'b0, BASE};
   assign acc_below = acc_diff[32];
   assign acc_off   = acc_diff[31:0];
   assign acc_over  = !acc_below && (|acc_off[31:AW+2]);
   assign acc_bad   = (acc_addr[1:0] != 2'b00) | acc_below | acc_over;
   assign acc_idx   = acc_off[AW+1:2];

   assign enter_resp = rst_n && (((state_reg == S_WAIT) && (cnt_reg == 4'd0)) ||
                                 (accept && (WAIT_STATES == 0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= 4'd0;
         we_reg    <= 1'b0;
         be_reg    <= 4'd0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         bad_reg   <= 1'b0;
         hold_reg  <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            we_reg    <= we;
            be_reg    <= be;
            addr_reg  <= Address;
            wdata_reg <= DataOut;
            bad_reg   <= acc_bad;
         end
         if ((state_reg == S_RESP) && !we_reg && !bad_reg) begin
            hold_reg <= rd_word;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_next = S_RESP;
               end else begin
                  state_next = S_WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = S_RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // One byte-wide RAM per lane so each byte enable maps onto its own write port.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] lane_rd_reg;

         always_ff @(posedge clk) begin
            if (enter_resp && !acc_bad) begin
               if (acc_we && acc_be[gi]) begin
                  lane_mem[acc_idx] <= acc_wdata[8*gi +: 8];
               end
               lane_rd_reg <= lane_mem[acc_idx];
            end
         end

         assign rd_word[8*gi +: 8] = lane_rd_reg;
      end
   endgenerate

   assign ack    = (state_reg == S_RESP);
   assign err    = (state_reg == S_RESP) && bad_reg;
   assign busy   = (state_reg != S_IDLE);
   assign DataIn = ((state_reg == S_RESP) && !we_reg && !bad_reg) ? rd_word : hold_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover 1, 0 and 3 wait states,
// and each task checks one feature against hand-computed values.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req  [3];
   logic        we   [3];
   logic [3:0]  be   [3];
   logic [31:0] addr [3];
   logic [31:0] wdat [3];
   logic [31:0] dout [3];
   logic        ack  [3];
   logic        err  [3];
   logic        busy [3];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // index 0: 1 wait state, 64 words at 0; index 1: 0 wait states, 16 words at 0x100; index 2: 3 wait states
   mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(0), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .be(be[0]), .Address(addr[0]),
      .DataOut(wdat[0]), .DataIn(dout[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
   mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h100), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .be(be[1]), .Address(addr[1]),
      .DataOut(wdat[1]), .DataIn(dout[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
   mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(0), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we[2]), .be(be[2]), .Address(addr[2]),
      .DataOut(wdat[2]), .DataIn(dout[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));

   // Issue one request; lat counts edges from the accepting edge to the ack cycle.
   task automatic do_access(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                            input logic [31:0] wd, input logic scramble, output int lat,
                            output logic e, output logic [31:0] q, output logic bsy,
                            output logic ack_after);
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdat[d] = wd;
      @(posedge clk);
      #1;
      req[d] = 1'b0;
      if (scramble) begin
         addr[d] = a ^ 32'h4;
         wdat[d] = ~wd;
      end
      lat = 0; e = 1'bx; q = 'x; bsy = 1'bx; ack_after = 1'bx;
      while (lat < 40) begin
         @(negedge clk);
         if (ack[d]) break;
         lat++;
      end
      if (lat < 40) begin
         e = err[d]; q = dout[d]; bsy = busy[d];
         @(negedge clk);
         ack_after = ack[d];
      end
      $display("txn dut%0d %s addr=%h be=%b wd=%h -> lat=%0d err=%b data=%h",
               d, w ? "ST" : "LD", a, b, wd, lat, e, q);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (dout[i] !== 32'd0) begin n_bad++; $display("FAIL reset_datain dut%0d: got %h want 0", i, dout[i]); end
         n_vec++; if (ack[i] !== 1'b0) begin n_bad++; $display("FAIL reset_ack dut%0d: got %b want 0", i, ack[i]); end
         n_vec++; if (err[i] !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d: got %b want 0", i, err[i]); end
         n_vec++; if (busy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b want 0", i, busy[i]); end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_store_load();
      int lat; logic e, bsy, aa; logic [31:0] q;
      do_access(0, 1'b1, 4'hF, 32'h10, 32'h12345678, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL t1_store_lat: got %0d want 1", lat); end
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL t1_store_err: got %b want 0", e); end
      n_vec++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_in_resp: got %b want 1", bsy); end
      n_vec++; if (aa !== 1'b0) begin n_bad++; $display("FAIL t1_ack_one_cycle: got %b want 0", aa); end
      do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL t1_load_lat: got %0d want 1", lat); end
      n_vec++; if (q !== 32'h12345678) begin n_bad++; $display("FAIL t1_load_data: got %h want 12345678", q); end
   endtask

   task automatic test_byte_enable();
      int lat; logic e, bsy, aa; logic [31:0] q;
      do_access(0, 1'b1, 4'b0101, 32'h10, 32'hAABBCCDD, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL t2_store_err: got %b want 0", e); end
      n_vec++; if (q !== 32'h12345678) begin n_bad++; $display("FAIL t2_datain_hold_on_store: got %h want 12345678", q); end
      do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'h12BB56DD) begin n_bad++; $display("FAIL t2_merge: got %h want 12bb56dd", q); end
      do_access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL t2_be0_err: got %b want 0", e); end
      do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'h12BB56DD) begin n_bad++; $display("FAIL t2_be0_nowrite: got %h want 12bb56dd", q); end
   endtask

   task automatic test_bad_access();
      int lat; logic e, bsy, aa; logic [31:0] q;
      do_access(0, 1'b0, 4'hF, 32'h11, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL t3_misaligned_err: got %b want 1", e); end
      n_vec++; if (q !== 32'h12BB56DD) begin n_bad++; $display("FAIL t3_misaligned_hold: got %h want 12bb56dd", q); end
      do_access(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL t3_range_err: got %b want 1", e); end
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL t3_range_lat: got %0d want 1", lat); end
      n_vec++; if (q !== 32'h12BB56DD) begin n_bad++; $display("FAIL t3_range_hold: got %h want 12bb56dd", q); end
      do_access(0, 1'b1, 4'hF, 32'h13, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL t3_bad_store_err: got %b want 1", e); end
      do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'h12BB56DD) begin n_bad++; $display("FAIL t3_bad_store_nowrite: got %h want 12bb56dd", q); end
      do_access(0, 1'b1, 4'hF, 32'hFC, 32'hDEADBEEF, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL t3_last_word_err: got %b want 0", e); end
      do_access(0, 1'b0, 4'hF, 32'hFC, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t3_last_word_data: got %h want deadbeef", q); end
   endtask

   task automatic test_below_base();
      int lat; logic e, bsy, aa; logic [31:0] q;
      do_access(1, 1'b0, 4'hF, 32'hFC, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL below_base_err: got %b want 1", e); end
      n_vec++; if (lat !== 0) begin n_bad++; $display("FAIL ws0_lat: got %0d want 0", lat); end
      do_access(1, 1'b1, 4'hF, 32'h100, 32'h0000A000, 1'b0, lat, e, q, bsy, aa);
      do_access(1, 1'b1, 4'hF, 32'h104, 32'h0000B001, 1'b0, lat, e, q, bsy, aa);
      do_access(1, 1'b1, 4'hF, 32'h108, 32'h0000C002, 1'b0, lat, e, q, bsy, aa);
      do_access(1, 1'b1, 4'hF, 32'h13C, 32'h13C13C13, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL base_last_word_err: got %b want 0", e); end
      do_access(1, 1'b1, 4'hF, 32'h140, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL base_past_end_err: got %b want 1", e); end
      do_access(1, 1'b0, 4'hF, 32'h13C, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'h13C13C13) begin n_bad++; $display("FAIL base_last_word_data: got %h want 13c13c13", q); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_word [3];
      int k;
      logic exp_ack;
      exp_word[0] = 32'h0000A000; exp_word[1] = 32'h0000B001; exp_word[2] = 32'h0000C002;
      k = 0;
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h100;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         exp_ack = ((cyc % 2) == 0);
         n_vec++; if (ack[1] !== exp_ack) begin n_bad++; $display("FAIL b2b_ack cyc%0d: got %b want %b", cyc, ack[1], exp_ack); end
         n_vec++; if (busy[1] !== exp_ack) begin n_bad++; $display("FAIL b2b_busy cyc%0d: got %b want %b", cyc, busy[1], exp_ack); end
         if (exp_ack && k < 3) begin
            n_vec++; if (dout[1] !== exp_word[k]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", k, dout[1], exp_word[k]); end
            $display("txn dut1 LD addr=%h b2b -> data=%h", addr[1], dout[1]);
            k++;
            addr[1] = 32'h100 + 32'(4 * k);
            if (k == 3) req[1] = 1'b0;
         end
      end
      req[1] = 1'b0;
   endtask

   task automatic test_reset_abort();
      int lat; logic e, bsy, aa; logic [31:0] q;
      logic seen_ack;
      do_access(2, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL ws3_lat: got %0d want 3", lat); end
      do_access(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'hCAFEF00D) begin n_bad++; $display("FAIL t5_preload: got %h want cafef00d", q); end
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdat[2] = 32'hFFFFFFFF;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req[2] = 1'b0;
      #1;
      n_vec++; if (busy[2] !== 1'b0) begin n_bad++; $display("FAIL t5_abort_busy: got %b want 0", busy[2]); end
      n_vec++; if (dout[2] !== 32'd0) begin n_bad++; $display("FAIL t5_abort_datain: got %h want 0", dout[2]); end
      seen_ack = 1'b0;
      repeat (3) begin @(negedge clk); seen_ack |= ack[2]; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); seen_ack |= ack[2]; end
      n_vec++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL t5_no_ack: got %b want 0", seen_ack); end
      $display("txn dut2 ST addr=00000020 aborted by reset");
      do_access(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'hCAFEF00D) begin n_bad++; $display("FAIL t5_old_value: got %h want cafef00d", q); end
   endtask

   task automatic test_latched_addr();
      int lat; logic e, bsy, aa; logic [31:0] q;
      do_access(2, 1'b1, 4'hF, 32'h34, 32'h11112222, 1'b0, lat, e, q, bsy, aa);
      do_access(2, 1'b1, 4'hF, 32'h30, 32'h5A5A0001, 1'b1, lat, e, q, bsy, aa);
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL t6_store_err: got %b want 0", e); end
      do_access(2, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'h5A5A0001) begin n_bad++; $display("FAIL t6_latched_word: got %h want 5a5a0001", q); end
      do_access(2, 1'b0, 4'hF, 32'h34, 32'h0, 1'b0, lat, e, q, bsy, aa);
      n_vec++; if (q !== 32'h11112222) begin n_bad++; $display("FAIL t6_neighbour: got %h want 11112222", q); end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdat[i] = 32'h0;
      end
      test_reset();
      test_store_load();
      test_byte_enable();
      test_bad_access();
      test_below_base();
      test_back_to_back();
      test_reset_abort();
      test_latched_addr();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
